// File: rtl/ipr_forwarder.sv
// ipr_forwarder: moves words from an upstream IPR FIFO to a downstream
// IPR FIFO through a small circular holding buffer.
module ipr_forwarder #(
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    output logic                           rd_req,
    input  logic                           rd_gnt,
    input  logic                           rd_rvalid,
    input  logic [31:0]                    rd_rdata,
    output logic                           wr_req,
    output logic                           wr_we,
    output logic [31:0]                    wr_wdata,
    input  logic                           wr_gnt,
    input  logic                           wr_rvalid,
    output logic [$clog2(BUF_DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]               fwd_count,
    output logic                           busy
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_WAIT
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_REQ,
        W_WAIT
    } wr_state_e;

    rd_state_e        rd_state_q;
    rd_state_e        rd_state_d;
    wr_state_e        wr_state_q;
    wr_state_e        wr_state_d;
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] wptr_d;
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W-1:0] rptr_d;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      mem_q [BUF_DEPTH];
    logic [31:0]      mem_d [BUF_DEPTH];
    logic             start_q;
    logic             start_d;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Read side: one outstanding upstream read at a time, only with room.
    // start_q holds off the first request one edge after reset release.
    always_comb begin
        rd_state_d = rd_state_q;
        push       = 1'b0;
        unique case (rd_state_q)
            R_IDLE: begin
                if (start_q && enable && (occ_q < OCC_FULL)) begin
                    rd_state_d = R_REQ;
                end
            end
            R_REQ: begin
                if (rd_gnt) begin
                    rd_state_d = R_WAIT;
                end else if (!enable) begin
                    rd_state_d = R_IDLE;
                end
            end
            R_WAIT: begin
                if (rd_rvalid) begin
                    push       = 1'b1;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Write side: one request per word, silent until the response returns
    // so the downstream FIFO never sees a second store for the same word.
    always_comb begin
        wr_state_d = wr_state_q;
        pop        = 1'b0;
        unique case (wr_state_q)
            W_IDLE: begin
                if ((occ_q != '0) || push) begin
                    wr_state_d = W_REQ;
                end
            end
            W_REQ: begin
                if (wr_gnt) begin
                    pop        = 1'b1;
                    wr_state_d = W_WAIT;
                end
            end
            W_WAIT: begin
                if (wr_rvalid) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Circular holding buffer with occupancy tracking.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (push) begin
            mem_d[wptr_q] = rd_rdata;
            wptr_d        = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Saturating count of words written downstream.
    always_comb begin
        cnt_d   = cnt_q;
        start_d = 1'b1;
        if (pop && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Output decode straight from state so reset clears them immediately.
    always_comb begin
        rd_req    = (rd_state_q == R_REQ);
        wr_req    = (wr_state_q == W_REQ);
        wr_we     = wr_req;
        wr_wdata  = wr_req ? mem_q[rptr_q] : 32'h0;
        occupancy = occ_q;
        fwd_count = cnt_q;
        busy      = (occ_q != '0) || (rd_state_q != R_IDLE) ||
                    (wr_state_q != W_IDLE);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= R_IDLE;
            wr_state_q <= W_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            occ_q      <= '0;
            cnt_q      <= '0;
            mem_q      <= '{default: '0};
            start_q    <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            occ_q      <= occ_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
            start_q    <= start_d;
        end
    end

endmodule

// File: tb/tb_ipr_forwarder.sv
// tb_ipr_forwarder: directed bench with upstream/downstream FIFO models.
// Downstream stores on every req&&we cycle while not full.
module tb_ipr_forwarder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        rd_req;
    logic        rd_gnt;
    logic        rd_rvalid;
    logic [31:0] rd_rdata = 32'hDEAD_BEEF;
    logic        wr_req;
    logic        wr_we;
    logic [31:0] wr_wdata;
    logic        wr_gnt;
    logic        wr_rvalid;
    logic [1:0]  occupancy;
    logic [3:0]  fwd_count;
    logic        busy;

    int n_chk = 0;
    int n_bad = 0;
    int occ_max = 0;

    logic [31:0] up_data [64];
    int          up_wr = 0;
    int          up_rd = 0;
    logic        rv_m = 1'b0;
    logic        rv_inj = 1'b0;
    logic        wv_m = 1'b0;
    logic        wv_inj = 1'b0;
    logic        dn_full = 1'b0;
    logic [31:0] dn_data [64];
    int          dn_cnt = 0;

    always #5 clk = ~clk;

    ipr_forwarder #(.BUF_DEPTH(2), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .rd_req    (rd_req),
        .rd_gnt    (rd_gnt),
        .rd_rvalid (rd_rvalid),
        .rd_rdata  (rd_rdata),
        .wr_req    (wr_req),
        .wr_we     (wr_we),
        .wr_wdata  (wr_wdata),
        .wr_gnt    (wr_gnt),
        .wr_rvalid (wr_rvalid),
        .occupancy (occupancy),
        .fwd_count (fwd_count),
        .busy      (busy)
    );

    assign rd_gnt    = rd_req && (up_rd != up_wr);
    assign rd_rvalid = rv_m | rv_inj;
    assign wr_gnt    = wr_req && !dn_full;
    assign wr_rvalid = wv_m | wv_inj;

    always @(posedge clk) begin
        rv_m <= rd_req && rd_gnt;
        if (rd_req && rd_gnt) begin
            rd_rdata <= up_data[up_rd];
            up_rd    <= up_rd + 1;
        end else begin
            rd_rdata <= 32'hDEAD_BEEF;
        end
        wv_m <= wr_req && wr_gnt;
        if (wr_req && wr_we && !dn_full && dn_cnt < 64) begin
            dn_data[dn_cnt] <= wr_wdata;
            dn_cnt          <= dn_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
    endtask

    task automatic push_up(input logic [31:0] w);
        up_data[up_wr] = w;
        up_wr = up_wr + 1;
    endtask

    task automatic wait_words(input int base, input int n, input int lim,
                              input string tag);
        for (int k = 0; k < lim && (dn_cnt - base) < n; k++) tick();
        check(tag, dn_cnt - base, n);
    endtask

    task automatic wait_idle(input int lim, input string tag);
        for (int k = 0; k < lim && busy; k++) tick();
        check(tag, busy, 1'b0);
    endtask

    task automatic wait_occ2(input int lim, input string tag);
        for (int k = 0; k < lim && occupancy != 2'd2; k++) tick();
        check(tag, occupancy, 2'd2);
    endtask

    initial begin
        int base;
        int viol;
        int errs;
        logic [31:0] w0;

        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        push_up(32'hA5A5_0001);
        tick();
        check("rst_rd_req", rd_req, 1'b0);
        check("rst_wr_req", wr_req, 1'b0);
        check("rst_wr_we", wr_we, 1'b0);
        check("rst_wdata", wr_wdata, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_occ", occupancy, 2'd0);
        check("rst_cnt", fwd_count, 4'd0);

        // single word
        #2 rst_n = 1'b1;
        tick();
        check("rd_req_edge1", rd_req, 1'b0);
        tick();
        check("rd_req_edge2", rd_req, 1'b1);
        tick();
        check("rd_req_wait", rd_req, 1'b0);
        enable = 1'b0;
        tick();
        check("s_wr_req", wr_req, 1'b1);
        check("s_wr_we", wr_we, 1'b1);
        check("s_wdata", wr_wdata, 32'hA5A5_0001);
        check("s_occ1", occupancy, 2'd1);
        tick();
        check("s_req_after_gnt", wr_req, 1'b0);
        check("s_occ0", occupancy, 2'd0);
        check("s_cnt", fwd_count, 4'd1);
        check("s_busy_wait", busy, 1'b1);
        tick();
        check("s_busy_end", busy, 1'b0);
        check("s_dn_cnt", dn_cnt, 1);
        check("s_dn_word", dn_data[0], 32'hA5A5_0001);

        // ordering and pointer wrap
        base = dn_cnt;
        for (int i = 1; i <= 8; i++) push_up(32'(i));
        occ_max = 0;
        enable = 1'b1;
        wait_words(base, 8, 300, "wrap_wait");
        enable = 1'b0;
        wait_idle(50, "wrap_idle");
        check("wrap_cnt", dn_cnt - base, 8);
        for (int i = 0; i < 8; i++)
            check("wrap_word", dn_data[base + i], 32'(i + 1));
        check("wrap_occ_le2", occ_max <= 2, 1'b1);

        // downstream full
        base = dn_cnt;
        dn_full = 1'b1;
        push_up(32'h11);
        push_up(32'h12);
        push_up(32'h13);
        enable = 1'b1;
        wait_occ2(50, "full_occ_wait");
        w0 = wr_wdata;
        viol = 0;
        for (int k = 0; k < 10; k++) begin
            wv_inj = (k == 3);
            tick();
            wv_inj = 1'b0;
            if (!wr_req || wr_wdata != w0 || rd_req || occupancy != 2'd2)
                viol++;
        end
        check("full_hold", viol, 0);
        check("full_head", w0, 32'h11);
        check("full_no_store", dn_cnt - base, 0);
        dn_full = 1'b0;
        wait_words(base, 3, 100, "full_drain");
        enable = 1'b0;
        wait_idle(50, "full_idle");
        check("full_nodup", dn_cnt - base, 3);
        check("full_w0", dn_data[base], 32'h11);
        check("full_w1", dn_data[base + 1], 32'h12);
        check("full_w2", dn_data[base + 2], 32'h13);

        // upstream empty
        enable = 1'b1;
        repeat (4) tick();
        check("empty_rd_req", rd_req, 1'b1);
        check("empty_busy", busy, 1'b1);
        check("empty_occ", occupancy, 2'd0);
        enable = 1'b0;
        tick();
        check("empty_rd_off", rd_req, 1'b0);
        check("empty_idle", busy, 1'b0);
        rv_inj = 1'b1;
        tick();
        rv_inj = 1'b0;
        tick();
        check("stray_rv_occ", occupancy, 2'd0);
        check("stray_rv_wr", wr_req, 1'b0);

        // reset in W_WAIT with one word held
        base = dn_cnt;
        dn_full = 1'b1;
        push_up(32'h21);
        push_up(32'h22);
        enable = 1'b1;
        wait_occ2(50, "mid_occ_wait");
        dn_full = 1'b0;
        tick();
        enable = 1'b0;
        check("mid_occ1", occupancy, 2'd1);
        check("mid_wwait", wr_req, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rd_req", rd_req, 1'b0);
        check("mid_wr_req", wr_req, 1'b0);
        check("mid_wr_we", wr_we, 1'b0);
        check("mid_wdata", wr_wdata, 32'h0);
        check("mid_busy", busy, 1'b0);
        check("mid_occ", occupancy, 2'd0);
        check("mid_cnt", fwd_count, 4'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("mid_no_stale", dn_cnt - base, 1);
        check("mid_word", dn_data[base], 32'h21);
        check("mid_idle", busy, 1'b0);

        // counter saturation
        base = dn_cnt;
        for (int i = 0; i < 20; i++) push_up(32'h100 + 32'(i));
        enable = 1'b1;
        wait_words(base, 20, 2000, "sat_wait");
        enable = 1'b0;
        wait_idle(50, "sat_idle");
        check("sat_cnt", fwd_count, 4'd15);
        check("sat_words", dn_cnt - base, 20);
        errs = 0;
        for (int i = 0; i < 20; i++)
            if (dn_data[base + i] != 32'h100 + 32'(i)) errs++;
        check("sat_order", errs, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/ipr_forwarder.md
IPR_FORWARDER -- requirements
Module: ipr_forwarder

Interface
REQ-001 Parameters: BUF_DEPTH, default 2, holding-buffer entries (>=1); CNT_W, default 16, width of the forwarded-word counter.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  allows new upstream reads when 1.
REQ-005 rd_req  output  1  read request to the upstream IPR FIFO.
REQ-006 rd_gnt  input  1  upstream grant, combinational in the rd_req cycle.
REQ-007 rd_rvalid  input  1  upstream response, one cycle after rd_gnt.
REQ-008 rd_rdata  input  32  upstream data, valid only when rd_rvalid=1.
REQ-009 wr_req  output  1  write request to the downstream IPR FIFO.
REQ-010 wr_we  output  1  write enable, equal to wr_req.
REQ-011 wr_wdata  output  32  buffer head word, driven 0 when wr_req=0.
REQ-012 wr_gnt  input  1  downstream grant, combinational in the wr_req cycle.
REQ-013 wr_rvalid  input  1  downstream response, one cycle after wr_gnt.
REQ-014 occupancy  output  $clog2(BUF_DEPTH+1)  words currently held.
REQ-015 fwd_count  output  CNT_W  words written downstream, saturating.
REQ-016 busy  output  1  1 when occupancy!=0 or either side is not IDLE.

Function
REQ-017 Read FSM states: R_IDLE, R_REQ, R_WAIT.
REQ-018 R_IDLE->R_REQ when enable=1 and occupancy<BUF_DEPTH.
REQ-019 rd_req=1 only in R_REQ.
REQ-020 R_REQ->R_WAIT on rd_gnt=1.
REQ-021 R_WAIT->R_IDLE on rd_rvalid=1, and rd_rdata is pushed at the buffer tail in that cycle.
REQ-022 Upstream grant only when non-empty, so R_REQ holds indefinitely while the upstream FIFO is empty.
REQ-023 Dropping enable in R_REQ returns to R_IDLE only if rd_gnt=0 that cycle.
REQ-024 Dropping enable in R_WAIT completes the response and pushes the word.
REQ-025 Write FSM states: W_IDLE, W_REQ, W_WAIT.
REQ-026 W_IDLE->W_REQ when occupancy>0, independent of enable.
REQ-027 wr_req=wr_we=1 only in W_REQ.
REQ-028 W_REQ->W_WAIT on wr_gnt=1, and the head is popped in that cycle.
REQ-029 W_WAIT->W_IDLE on wr_rvalid=1.
REQ-030 wr_req SHALL be 0 in every cycle after the grant cycle until wr_rvalid, because the downstream FIFO stores on every req&&we cycle while not full.
REQ-031 Exactly one downstream write per buffered word, in its wr_gnt cycle.
REQ-032 Downstream full: wr_gnt=0, so W_REQ holds with wr_wdata stable.
REQ-033 Buffer is a circular FIFO of BUF_DEPTH words; read/write pointers wrap from BUF_DEPTH-1 to 0.
REQ-034 Simultaneous push (rd_rvalid) and pop (wr_gnt) leave occupancy unchanged and preserve word order.
REQ-035 Read FSM never leaves R_IDLE when occupancy=BUF_DEPTH, so a push never overflows.
REQ-036 W_IDLE->W_REQ in the cycle after a push into an empty buffer, giving minimum latency rd_rvalid -> wr_req of 1 cycle.
REQ-037 fwd_count increments by 1 on each wr_gnt in W_REQ.
REQ-038 fwd_count saturates at 2^CNT_W-1.
REQ-039 Unexpected rd_rvalid outside R_WAIT is ignored (no push).
REQ-040 Unexpected wr_rvalid outside W_WAIT is ignored.

Reset
REQ-041 rst_n=0 immediately forces both FSMs to IDLE and clears the pointers, occupancy=0 and fwd_count=0.
REQ-042 During rst_n=0: rd_req=0, wr_req=0, wr_we=0, wr_wdata=0, busy=0.
REQ-043 Buffered words and in-flight transactions are discarded on reset, including reset asserted mid-operation.
REQ-044 First rd_req may assert no earlier than the second rising edge after rst_n deasserts with enable=1.

Verification
REQ-045 Single word: upstream holds 0xA5A5_0001, enable=1 -> cycle sequence rd_req/rd_gnt, rd_rvalid, wr_req/wr_gnt with wr_wdata=0xA5A5_0001, wr_rvalid; fwd_count=1, busy=0 afterwards.
REQ-046 Ordering/wrap: push 0x1..0x8 upstream with BUF_DEPTH=2 -> downstream receives 0x1..0x8 in order, exactly 8 write-grant cycles, occupancy never >2.
REQ-047 Downstream full: hold wr_gnt=0 for 10 cycles -> wr_req stays 1 with constant wr_wdata, occupancy reaches 2, rd_req stays 0; on release all words drain with no duplicates.
REQ-048 Upstream empty: enable=1, no data -> rd_req held 1, no push; busy=1 (R_REQ); after enable=0 -> rd_req=0, busy=0.
REQ-049 Mid-transfer reset: assert rst_n=0 in W_WAIT with occupancy=1 -> all outputs 0 asynchronously; after release no stale word is written.
REQ-050 Saturation: CNT_W=4, forward 20 words -> fwd_count stops at 15, all 20 words delivered.
